// File: rtl/bit_stream_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stage feeding the "111" detector.
package bit_stream_serializer_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit that leaves the shift register first, given its two ends.
   function automatic logic sel_out_bit(input bit msb_first, input logic msb, input logic lsb);
      return msb_first ? msb : lsb;
   endfunction

   // MSB-first frames drain toward the top, so the register shifts left.
   function automatic bit shifts_left(input bit msb_first);
      return msb_first;
   endfunction

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word handshake in, serial line plus framing flags out.
interface bit_stream_serializer_if
   import bit_stream_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ser_out;
   logic              ser_active;
   logic              frame_done;

   modport master (
      output in_data, in_valid,
      input  in_ready, ser_out, ser_active, frame_done
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, ser_out, ser_active, frame_done
   );
endinterface

// File: rtl/bit_stream_serializer_hold_reg.sv
// One-entry holding register: accepts a word when empty, released by take.
module ser_hold_reg
   import bit_stream_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              take
);
   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   // Ready depends only on state and reset, never on valid_in.
   assign ready_out = !valid_q && !reset;
   assign data_out  = data_q;
   assign valid_out = valid_q;

   // Accept and take are mutually exclusive: take needs valid_q, accept needs !valid_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (valid_in && ready_out) begin
         valid_q <= 1'b1;
         data_q  <= data_in;
      end else if (take) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage: one bit per clock, gapless between back-to-back words.
module bit_stream_serializer
   import bit_stream_serializer_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input logic                     clk,
   input logic                     reset,
   bit_stream_serializer_if.slave  bus
);
   localparam int unsigned     CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DATA_W-1:0] sreg, sreg_n;
   logic              ser_q, ser_n;
   logic              active_q, done_q;
   logic [DATA_W-1:0] hold_data;
   logic              hold_valid;
   logic              take;
   logic              load;

   function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v);
      return shifts_left(MSB_FIRST) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
   endfunction

   ser_hold_reg #(.DATA_W(DATA_W)) u_hold (
      .clk       (clk),
      .reset     (reset),
      .data_in   (bus.in_data),
      .valid_in  (bus.in_valid),
      .ready_out (bus.in_ready),
      .data_out  (hold_data),
      .valid_out (hold_valid),
      .take      (take)
   );

   // Next state: a load emits the first bit immediately and parks the rest in sreg.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = sreg;
      ser_n   = ser_q;
      take    = 1'b0;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (hold_valid) load = 1'b1;
            else            ser_n = IDLE_BIT;
         end
         SHIFT: begin
            if (cnt != LAST) begin
               ser_n  = sel_out_bit(MSB_FIRST, sreg[DATA_W-1], sreg[0]);
               sreg_n = shift_word(sreg);
               cnt_n  = cnt + CNT_W'(1);
            end else if (hold_valid) begin
               load = 1'b1;
            end else begin
               ser_n   = IDLE_BIT;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
      endcase
      if (load) begin
         take    = 1'b1;
         ser_n   = sel_out_bit(MSB_FIRST, hold_data[DATA_W-1], hold_data[0]);
         sreg_n  = shift_word(hold_data);
         cnt_n   = '0;
         state_n = SHIFT;
      end
   end

   // State and registered outputs; flags are decoded from next-state so they align with ser_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         sreg     <= '0;
         ser_q    <= IDLE_BIT;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sreg     <= sreg_n;
         ser_q    <= ser_n;
         active_q <= (state_n == SHIFT);
         done_q   <= (state_n == SHIFT) && (cnt_n == LAST);
      end
   end

   assign bus.ser_out    = ser_q;
   assign bus.ser_active = active_q;
   assign bus.frame_done = done_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances against a bit-queue reference model.
module tb_bit_stream_serializer;
   localparam int unsigned W        = 8;
   localparam bit          IDLE_LVL = 1'b0;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;

   always #5 clk = ~clk;

   bit_stream_serializer_if #(.DATA_W(W)) ifm ();
   bit_stream_serializer_if #(.DATA_W(W)) ifl ();

   assign ifm.in_valid = in_valid;
   assign ifm.in_data  = in_data;
   assign ifl.in_valid = in_valid;
   assign ifl.in_data  = in_data;

   bit_stream_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_LVL)) dut_m (
      .clk(clk), .reset(reset), .bus(ifm));
   bit_stream_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_LVL)) dut_l (
      .clk(clk), .reset(reset), .bus(ifl));

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: one pending word plus the queue of bits still to appear on each line.
   bit           hold_v = 1'b0;
   logic [W-1:0] hold_w = '0;
   bit           line_m[$];
   bit           line_l[$];

   always @(posedge clk) begin
      bit acc;
      if (reset) begin
         hold_v = 1'b0;
         line_m.delete();
         line_l.delete();
      end else begin
         acc = in_valid && !hold_v;
         if (line_m.size() <= 1 && hold_v) begin
            line_m.delete();
            line_l.delete();
            for (int i = W - 1; i >= 0; i--) line_m.push_back(hold_w[i]);
            for (int i = 0; i < W; i++)      line_l.push_back(hold_w[i]);
            hold_v = 1'b0;
         end else if (line_m.size() > 0) begin
            void'(line_m.pop_front());
            void'(line_l.pop_front());
         end
         if (acc) begin
            hold_v = 1'b1;
            hold_w = in_data;
         end
      end
   end

   // Per-cycle comparison plus stream statistics for the directed tests.
   bit mon_m[$];
   bit mon_l[$];
   int act_cnt = 0, fd_cnt = 0, rise_cnt = 0, det_hits = 0, nonidle_cnt = 0, run = 0;
   bit prev_act = 1'b0;

   always begin
      @(posedge clk);
      #1;
      chk("cyc_ready_m",  ifm.in_ready,   !hold_v && !reset);
      chk("cyc_ready_l",  ifl.in_ready,   !hold_v && !reset);
      chk("cyc_ser_m",    ifm.ser_out,    (line_m.size() > 0) ? line_m[0] : IDLE_LVL);
      chk("cyc_ser_l",    ifl.ser_out,    (line_l.size() > 0) ? line_l[0] : IDLE_LVL);
      chk("cyc_active_m", ifm.ser_active, line_m.size() > 0);
      chk("cyc_active_l", ifl.ser_active, line_l.size() > 0);
      chk("cyc_done_m",   ifm.frame_done, line_m.size() == 1);
      chk("cyc_done_l",   ifl.frame_done, line_l.size() == 1);
      if (ifm.ser_active) begin
         mon_m.push_back(ifm.ser_out);
         mon_l.push_back(ifl.ser_out);
         act_cnt++;
      end
      if (ifm.ser_active && !prev_act) rise_cnt++;
      prev_act = ifm.ser_active;
      if (ifm.frame_done) fd_cnt++;
      if (ifm.ser_out !== IDLE_LVL) nonidle_cnt++;
      run = (ifm.ser_out === 1'b1) ? run + 1 : 0;
      if (run >= 3) det_hits++;
   end

   task automatic clear_stats();
      mon_m.delete();
      mon_l.delete();
      act_cnt = 0; fd_cnt = 0; rise_cnt = 0; det_hits = 0; nonidle_cnt = 0;
   endtask

   function automatic logic [31:0] pack(input bit q[$]);
      logic [31:0] r = '0;
      foreach (q[j]) r = {r[30:0], q[j]};
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [W-1:0] w);
      bit done = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         done = ifm.in_ready;
         @(negedge clk);
      end
      chk("push_accept", done, 1'b1);
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] data;
      logic [W-1:0] exp_m;
      logic [W-1:0] exp_l;
      int           hits;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{data: 8'hE0, exp_m: 8'hE0, exp_l: 8'h07, hits: 1};
      tbl[1] = '{data: 8'h07, exp_m: 8'h07, exp_l: 8'hE0, hits: 1};
      tbl[2] = '{data: 8'hAA, exp_m: 8'hAA, exp_l: 8'h55, hits: 0};
      tbl[3] = '{data: 8'h81, exp_m: 8'h81, exp_l: 8'h81, hits: 0};
      tbl[4] = '{data: 8'hFF, exp_m: 8'hFF, exp_l: 8'hFF, hits: 6};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle line
      clear_stats();
      repeat (20) @(negedge clk);
      chk("idle_active",  act_cnt, 0);
      chk("idle_done",    fd_cnt, 0);
      chk("idle_nonidle", nonidle_cnt, 0);

      // Single words, both bit orders
      for (int i = 0; i < 5; i++) begin
         clear_stats();
         push(tbl[i].data);
         repeat (12) @(negedge clk);
         chk("single_len",    mon_m.size(), W);
         chk("single_bits_m", pack(mon_m), 32'(tbl[i].exp_m));
         chk("single_bits_l", pack(mon_l), 32'(tbl[i].exp_l));
         chk("single_done",   fd_cnt, 1);
         chk("single_active", act_cnt, W);
         chk("single_det",    det_hits, tbl[i].hits);
      end

      // Back-to-back FF then 0F
      clear_stats();
      push(8'hFF);
      push(8'h0F);
      repeat (20) @(negedge clk);
      chk("b2b_bits",   pack(mon_m), 32'h0000FF0F);
      chk("b2b_active", act_cnt, 16);
      chk("b2b_gapless", rise_cnt, 1);
      chk("b2b_done",   fd_cnt, 2);

      // Backpressure: three words with valid held
      clear_stats();
      push(8'hA5);
      push(8'h3C);
      push(8'h96);
      repeat (30) @(negedge clk);
      chk("bp_bits_m",  pack(mon_m), 32'h00A53C96);
      chk("bp_bits_l",  pack(mon_l), 32'h00A53C69);
      chk("bp_active",  act_cnt, 24);
      chk("bp_gapless", rise_cnt, 1);

      // Reset after bit 3 of AA
      clear_stats();
      push(8'hAA);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_ready_low", ifm.in_ready, 1'b0);
      @(negedge clk);
      chk("rst_ser_idle",   ifm.ser_out, IDLE_LVL);
      chk("rst_active_low", ifm.ser_active, 1'b0);
      chk("rst_ready_hold", ifm.in_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("rst_ready_high", ifm.in_ready, 1'b1);
      chk("rst_partial", pack(mon_m), 32'h0000000A);
      clear_stats();
      push(8'h81);
      repeat (12) @(negedge clk);
      chk("post_rst_bits",   pack(mon_m), 32'h00000081);
      chk("post_rst_active", act_cnt, W);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 63) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = W'($urandom);
         @(negedge clk);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the team's Moore "111" sequence detector.
- Accepts DATA_W-bit words on a valid/ready handshake and drives them out one bit per clock on a continuous serial line.
- The detector samples that line every cycle.
- A one-entry holding register lets back-to-back words stream with no idle gap between frames.

Parameters:
DATA_W, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first
IDLE_BIT, 0, level driven on ser_out when no frame is active

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial bit stream, registered, feeds the detector's in
ser_active  output  1  high while ser_out carries a frame bit
frame_done  output  1  high during the cycle the last bit of a frame is on ser_out

Behaviour:
- Interface: clock is clk; reset is reset, synchronous, active-high.
- Reset values:
  - ser_out = IDLE_BIT; ser_active = 0; frame_done = 0.
  - Holding register empty; state IDLE; bit counter 0.
  - in_ready is forced low while reset is high.
- Handshake:
  - in_ready = !hold_valid && !reset. It is a pure function of registers and reset, with no combinational path from in_valid.
  - A word is accepted on an edge where in_valid && in_ready; it is written into the holding register and hold_valid is set.
  - in_data is don't-care when in_valid is low.
- State machine, states IDLE and SHIFT:
  - IDLE with hold_valid=1 at an edge: load the shift register from the holding register and clear hold_valid. Drive ser_out with the first bit (MSB or LSB per MSB_FIRST). Set cnt=0 and go to SHIFT.
  - IDLE with hold_valid=0: stay; ser_out = IDLE_BIT.
  - SHIFT with cnt < DATA_W-1: ser_out takes the next bit, the shift register shifts, and cnt increments.
  - SHIFT with cnt == DATA_W-1 (last bit currently on ser_out) and hold_valid=1: reload from the holding register exactly as from IDLE and stay in SHIFT. This gives a gapless frame boundary.
  - SHIFT with cnt == DATA_W-1 and hold_valid=0: ser_out = IDLE_BIT; go to IDLE.
- Outputs:
  - ser_active = (state == SHIFT).
  - frame_done = (state == SHIFT && cnt == DATA_W-1). It is decoded from registers only.
- Latency:
  - Acceptance at edge E0 puts the first bit on ser_out after edge E1.
  - Bit k of the frame is on ser_out after edge E1+k.
- Throughput: one word per DATA_W cycles sustained. The holding register frees one cycle after each load, so an upstream that keeps in_valid high never starves the line.
- Width rules: cnt is $clog2(DATA_W) bits. The shift register is DATA_W bits and shifts toward the output end with zero fill.
- Boundary conditions:
  - Holding register full: in_ready low; in_valid is ignored, nothing is dropped or overwritten.
  - Accept and load never coincide: a load empties the holding register, and in_ready only rises the cycle after.
  - Reset mid-frame: the frame is abandoned; ser_out returns to IDLE_BIT on the next cycle and the holding register is discarded.
  - No partial frame is ever emitted after reset deasserts.

Decomposition:
- Package bit_stream_serializer_pkg holds:
  - state enum {IDLE, SHIFT} (1 bit);
  - default DATA_W constant;
  - a function selecting the output bit and shift direction from MSB_FIRST.
- Sub-module ser_hold_reg: one-entry valid/ready holding register with a load/consume interface. Its ports are data_in, valid_in, ready_out, data_out, valid_out, take.
- The top module contains the FSM, counter and shift register.

Test Plan:
- Single word, DATA_W=8, MSB_FIRST=1:
  - Stimulus: in_data=8'hE0 accepted at E0.
  - Required response: ser_out = 1,1,1,0,0,0,0,0 after E1..E8, then IDLE_BIT.
  - frame_done high only in the cycle after E8; ser_active high for exactly 8 cycles.
  - A downstream "111" detector driven from ser_out asserts out for 1 cycle.
- Back-to-back:
  - Stimulus: in_valid held high with 8'hFF then 8'h0F.
  - Required response: 16 consecutive bits 1x8,0x4,1x4 with no IDLE_BIT gap.
  - in_ready low from the acceptance of the first word until the cycle after its load.
- LSB-first:
  - Stimulus: MSB_FIRST=0, in_data=8'h07.
  - Required response: ser_out = 1,1,1,0,0,0,0,0.
- Backpressure:
  - Stimulus: present three words while in_valid stays high.
  - Required response: the third word is accepted only after the second leaves the holding register; all 24 bits appear in order with no word lost or duplicated.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle after bit 3 of 8'hAA.
  - Required response: ser_out = IDLE_BIT and ser_active = 0 the next cycle; in_ready low during reset and high the cycle after.
  - A subsequent word 8'h81 serializes correctly from bit 0.
- Idle line:
  - Stimulus: no in_valid for 20 cycles after reset.
  - Required response: ser_out stays IDLE_BIT; frame_done and ser_active stay 0 throughout.
